fc_layer: RTL and testbench

- Fully-connected (dense) layer. Sits directly downstream of the 2×2 max-pool stage.
- Reads the flattened pooled feature map from the POOL buffer. Reads weights and biases from external synchronous ROMs.
- Computes OUT_DIM fixed-point dot products and writes the logits into a FC output buffer for the argmax/readout stage.
- Runs one pass per start pulse and signals done.

---
 rtl/fc_layer.sv | 150 +++++++++++++++
 tb/tb_fc_layer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer.sv
// fc_layer: dense layer; OUT_DIM fixed-point dot products of the pooled map against ROM weights plus bias.
// Define FC_RELU_EN to clamp negative outputs to zero; otherwise raw saturated logits are written.
module fc_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 7,
  parameter int IN_DIM = 1568,
  parameter int OUT_DIM = 10,
  localparam int IW = IN_DIM > 1 ? $clog2(IN_DIM) : 1,
  localparam int WW = IN_DIM * OUT_DIM > 1 ? $clog2(IN_DIM * OUT_DIM) : 1,
  localparam int OW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [IW-1:0]         in_addr,
  output logic                  in_en,
  input  logic [DATA_WIDTH-1:0] in_q,
  output logic [WW-1:0]         w_addr,
  output logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_q,
  output logic [OW-1:0]         b_addr,
  output logic                  b_en,
  input  logic [DATA_WIDTH-1:0] b_q,
  output logic [OW-1:0]         out_addr,
  output logic                  out_en,
  output logic                  out_we,
  output logic [DATA_WIDTH-1:0] out_d,
  output logic                  done
);
  localparam int AW = 2 * DATA_WIDTH + $clog2(IN_DIM) + 1;
  localparam logic signed [AW-1:0] SMAX = AW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, FINISH} state_t;
  state_t r_state, w_state;
  logic [IW-1:0] r_in_addr, w_in_addr;
  logic [WW-1:0] r_w_addr, w_w_addr;
  logic [OW-1:0] r_b_addr, w_b_addr, r_out_addr, w_out_addr;
  logic [DATA_WIDTH-1:0] r_out_d, w_out_d, w_sat, w_res;
  logic r_issue, w_issue, r_bias_en, w_bias_en, r_write, w_write, r_done, w_done;
  logic r_drain, w_drain, r_v, r_f;
  logic signed [AW-1:0] r_acc, w_bias_ext, w_sh;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  assign in_addr = r_in_addr;
  assign in_en = r_issue;
  assign w_addr = r_w_addr;
  assign w_en = r_issue;
  assign b_addr = r_b_addr;
  assign b_en = r_bias_en;
  assign out_addr = r_out_addr;
  assign out_en = r_write;
  assign out_we = r_write;
  assign out_d = r_out_d;
  assign done = r_done;
  assign w_prod = $signed(in_q) * $signed(w_q);
  assign w_bias_ext = AW'($signed(b_q)) <<< FRAC_BITS;
  assign w_sh = r_acc >>> FRAC_BITS;
  assign w_sat = w_sh > SMAX ? SMAX[DATA_WIDTH-1:0] : w_sh < SMIN ? SMIN[DATA_WIDTH-1:0] : w_sh[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
  assign w_res = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif
  // Weights of consecutive neurons are contiguous, so w_addr just keeps counting across neurons.
  always_comb begin
    w_state = r_state;
    w_in_addr = r_in_addr;
    w_w_addr = r_w_addr;
    w_b_addr = r_b_addr;
    w_out_addr = r_out_addr;
    w_out_d = r_out_d;
    w_issue = 1'b0;
    w_bias_en = 1'b0;
    w_write = 1'b0;
    w_done = 1'b0;
    w_drain = r_drain;
    case (r_state)
      IDLE: if (start) begin
        w_in_addr = '0;
        w_w_addr = '0;
        w_b_addr = '0;
        w_issue = 1'b1;
        w_bias_en = 1'b1;
        w_state = IN_DIM == 1 ? DRAIN : MAC;
      end
      MAC: begin
        w_in_addr = r_in_addr + IW'(1);
        w_w_addr = r_w_addr + WW'(1);
        w_issue = 1'b1;
        w_state = w_in_addr == IW'(IN_DIM - 1) ? DRAIN : MAC;
      end
      DRAIN: begin
        w_drain = ~r_drain;
        w_state = r_drain ? WRITE : DRAIN;
      end
      WRITE: begin
        w_out_addr = r_b_addr;
        w_out_d = w_res;
        w_write = 1'b1;
        if (r_b_addr == OW'(OUT_DIM - 1)) w_state = FINISH;
        else begin
          w_b_addr = r_b_addr + OW'(1);
          w_in_addr = '0;
          w_w_addr = r_w_addr + WW'(1);
          w_issue = 1'b1;
          w_bias_en = 1'b1;
          w_state = IN_DIM == 1 ? DRAIN : MAC;
        end
      end
      FINISH: begin
        w_done = 1'b1;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  // r_v/r_f trail the issue by one more edge so the accumulator captures exactly when q is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_in_addr <= '0;
      r_w_addr <= '0;
      r_b_addr <= '0;
      r_out_addr <= '0;
      r_out_d <= '0;
      r_issue <= 1'b0;
      r_bias_en <= 1'b0;
      r_write <= 1'b0;
      r_done <= 1'b0;
      r_drain <= 1'b0;
      r_v <= 1'b0;
      r_f <= 1'b0;
      r_acc <= '0;
    end else begin
      r_state <= w_state;
      r_in_addr <= w_in_addr;
      r_w_addr <= w_w_addr;
      r_b_addr <= w_b_addr;
      r_out_addr <= w_out_addr;
      r_out_d <= w_out_d;
      r_issue <= w_issue;
      r_bias_en <= w_bias_en;
      r_write <= w_write;
      r_done <= w_done;
      r_drain <= w_drain;
      r_v <= r_issue;
      r_f <= r_issue && r_in_addr == '0;
      if (r_v) r_acc <= (r_f ? w_bias_ext : r_acc) + AW'(w_prod);
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: randomized and directed checks of fc_layer against an arithmetic dot-product reference.
module tb_fc_layer;
  localparam int ID = 4;
  localparam int OD = 2;
  localparam int FB = 7;
  localparam int P = ID + 2;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] in_addr;
  logic [2:0] w_addr;
  logic [0:0] b_addr, out_addr;
  logic in_en, w_en, b_en, out_en, out_we, done;
  logic [15:0] in_q = 0, w_q = 0, b_q = 0, out_d;
  logic [15:0] in_mem[ID], w_mem[ID*OD], b_mem[OD];
  int checks = 0, failures = 0, cyc = 0, s_edge = 0;
  int wr_a[$], wr_e[$], dn_e[$], is_i[$], is_w[$], is_b[$];
  logic [15:0] wr_d[$];

  fc_layer #(.DATA_WIDTH(16), .FRAC_BITS(FB), .IN_DIM(ID), .OUT_DIM(OD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_addr(in_addr), .in_en(in_en), .in_q(in_q),
    .w_addr(w_addr), .w_en(w_en), .w_q(w_q),
    .b_addr(b_addr), .b_en(b_en), .b_q(b_q),
    .out_addr(out_addr), .out_en(out_en), .out_we(out_we), .out_d(out_d),
    .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (in_en) in_q <= in_mem[in_addr];
    if (w_en) w_q <= w_mem[w_addr];
    if (b_en) b_q <= b_mem[b_addr];
  end
  // Edge index of an event = cyc-1 when observed on the following falling edge.
  always @(negedge clk) begin
    if (out_en && out_we) begin
      wr_a.push_back(int'(out_addr));
      wr_d.push_back(out_d);
      wr_e.push_back(cyc - 1);
    end
    if (done) dn_e.push_back(cyc - 1);
    if (in_en) is_i.push_back(int'(in_addr));
    if (w_en) is_w.push_back(int'(w_addr));
    if (b_en) is_b.push_back(int'(b_addr));
  end

  function automatic int post(input int v);
`ifdef FC_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] model(input int o);
    longint acc;
    acc = longint'($signed(b_mem[o])) * (longint'(1) << FB);
    for (int i = 0; i < ID; i++) acc += longint'($signed(in_mem[i])) * longint'($signed(w_mem[o*ID+i]));
    acc = acc >>> FB;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(post(int'(acc)));
  endfunction

  task automatic fill(input int iv, input int wv, input int bv);
    foreach (in_mem[i]) in_mem[i] = 16'(iv);
    foreach (w_mem[i]) w_mem[i] = 16'(wv);
    foreach (b_mem[i]) b_mem[i] = 16'(bv);
  endtask

  task automatic fill_random(input bit full);
    foreach (in_mem[i]) in_mem[i] = full ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 300);
    foreach (w_mem[i]) w_mem[i] = full ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 300);
    foreach (b_mem[i]) b_mem[i] = 16'(int'($urandom_range(0, 2000)) - 1000);
  endtask

  task automatic clear_logs;
    wr_a.delete(); wr_d.delete(); wr_e.delete(); dn_e.delete();
    is_i.delete(); is_w.delete(); is_b.delete();
  endtask

  task automatic start_pass;
    @(negedge clk);
    clear_logs();
    s_edge = cyc;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (dn_e.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_en, w_en, b_en, out_en, out_we, done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000", {in_en, w_en, b_en, out_en, out_we, done});
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if ({in_addr, w_addr, b_addr, out_addr} !== 7'b0) begin
      failures++;
      $display("FAIL reset_addr: got %b expected 0", {in_addr, w_addr, b_addr, out_addr});
    end
    checks++;
    if (out_d !== 16'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: got out_d=%h done=%b expected 0 0", out_d, done);
    end
  endtask

  task automatic test_datapath;
    int tbl[7][4] = '{'{128, 64, 0, 256}, '{1, -1, 0, -1}, '{1, 1, 0, 0}, '{0, 0, 128, 128},
                      '{32767, 32767, 0, 32767}, '{32767, -32768, 0, -32768}, '{128, -64, 0, -256}};
    logic [15:0] exp;
    for (int r = 0; r < 7 + 8; r++) begin
      if (r < 7) fill(tbl[r][0], tbl[r][1], tbl[r][2]);
      else fill_random(r >= 13);
      start_pass();
      wait_done();
      checks++;
      if (wr_d.size() != OD) begin
        failures++;
        $display("FAIL dp_count row%0d: got %0d writes expected %0d", r, wr_d.size(), OD);
      end else for (int o = 0; o < OD; o++) begin
        exp = r < 7 ? 16'(post(tbl[r][3])) : model(o);
        checks++;
        if (wr_d[o] !== exp || wr_a[o] != o) begin
          failures++;
          $display("FAIL dp_value row%0d o%0d: got addr=%0d d=%0d expected addr=%0d d=%0d",
                   r, o, wr_a[o], $signed(wr_d[o]), o, $signed(exp));
        end
      end
    end
  endtask

  task automatic test_timing_order;
    fill(128, 64, 0);
    start_pass();
    wait_done();
    checks++;
    if (wr_e.size() != OD || wr_e[0] - s_edge != P || wr_e[1] - s_edge != 2 * P) begin
      failures++;
      $display("FAIL write_edges: got n=%0d first=%0d expected edges %0d,%0d",
               wr_e.size(), wr_e.size() ? wr_e[0] - s_edge : -1, P, 2 * P);
    end
    checks++;
    if (dn_e.size() != 1 || dn_e[0] - s_edge != OD * P + 1) begin
      failures++;
      $display("FAIL done_edge: got n=%0d edge=%0d expected one at %0d",
               dn_e.size(), dn_e.size() ? dn_e[0] - s_edge : -1, OD * P + 1);
    end
    checks++;
    if (is_w.size() != ID * OD || is_i.size() != ID * OD) begin
      failures++;
      $display("FAIL issue_count: got w=%0d i=%0d expected %0d", is_w.size(), is_i.size(), ID * OD);
    end else for (int j = 0; j < ID * OD; j++) begin
      checks++;
      if (is_w[j] != j || is_i[j] != j % ID) begin
        failures++;
        $display("FAIL addr_order j%0d: got w=%0d i=%0d expected w=%0d i=%0d", j, is_w[j], is_i[j], j, j % ID);
      end
    end
    checks++;
    if (is_b.size() != OD || is_b[0] != 0 || is_b[1] != 1) begin
      failures++;
      $display("FAIL bias_order: got n=%0d expected 0,1", is_b.size());
    end
  endtask

  task automatic test_start_ignored;
    fill_random(0);
    start_pass();
    @(negedge clk);
    start = 1;
    repeat (2) @(negedge clk);
    start = 0;
    wait_done();
    checks++;
    if (wr_d.size() != OD || dn_e.size() != 1 || is_i.size() != ID * OD) begin
      failures++;
      $display("FAIL start_ignored: got writes=%0d dones=%0d issues=%0d expected %0d 1 %0d",
               wr_d.size(), dn_e.size(), is_i.size(), OD, ID * OD);
    end
  endtask

  task automatic test_reset_mid;
    fill(128, 64, 0);
    start_pass();
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({in_en, w_en, b_en, out_en, out_we, done} !== 6'b0) begin
      failures++;
      $display("FAIL abort_ctrl: got %b expected 000000", {in_en, w_en, b_en, out_en, out_we, done});
    end
    @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_d.size() != 0 || dn_e.size() != 0 || is_i.size() != 3) begin
      failures++;
      $display("FAIL abort_quiet: got writes=%0d dones=%0d issues=%0d expected 0 0 3",
               wr_d.size(), dn_e.size(), is_i.size());
    end
    fill_random(0);
    start_pass();
    wait_done();
    checks++;
    if (wr_d.size() != OD || wr_d[0] !== model(0) || wr_d[1] !== model(1)) begin
      failures++;
      $display("FAIL after_abort: got n=%0d d0=%0d expected d0=%0d", wr_d.size(),
               wr_d.size() ? $signed(wr_d[0]) : 0, $signed(model(0)));
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    fill_random(0);
    @(negedge clk);
    clear_logs();
    s_edge = cyc;
    start = 1;
    for (int n = 0; n < 100 && nd < 2; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    start = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (dn_e.size() != 2 || dn_e[0] - s_edge != OD * P + 1 || dn_e[1] - s_edge != 2 * (OD * P + 2) - 1) begin
      failures++;
      $display("FAIL b2b_done: got n=%0d expected edges %0d,%0d", dn_e.size(), OD * P + 1, 2 * (OD * P + 2) - 1);
    end
    checks++;
    if (wr_e.size() != 2 * OD) begin
      failures++;
      $display("FAIL b2b_count: got %0d writes expected %0d", wr_e.size(), 2 * OD);
    end else for (int j = 0; j < 2 * OD; j++) begin
      checks++;
      if (wr_e[j] - s_edge != (j / OD) * (OD * P + 2) + (j % OD + 1) * P || wr_d[j] !== model(j % OD)) begin
        failures++;
        $display("FAIL b2b_write j%0d: got edge=%0d d=%0d expected edge=%0d d=%0d", j, wr_e[j] - s_edge,
                 $signed(wr_d[j]), (j / OD) * (OD * P + 2) + (j % OD + 1) * P, $signed(model(j % OD)));
      end
    end
  endtask

  initial begin
    fill(0, 0, 0);
    test_reset();
    test_datapath();
    test_timing_order();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
